// File: rtl/rr_bus_sched_pkg.sv
// rr_bus_sched_pkg: shared types, widths and pointer helpers for the round-robin bus scheduler.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package rr_bus_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  localparam int GRANT_W = 3;
  localparam int STAT_W  = 16;
  localparam int BEAT_W  = 4;
  localparam logic [31:0] INIT_VAL_DEF = 32'd42;

  // Advance a requester index by k positions, wrapping modulo nreq.
  function automatic logic [GRANT_W-1:0] ptr_add(input logic [GRANT_W-1:0] p, input int k,
                                                 input int nreq);
    int s;
    s = int'(p) + k;
    if (s >= nreq) s = s - nreq;
    return GRANT_W'(s);
  endfunction

  // Requester after p, wrapping at nreq-1 back to 0.
  function automatic logic [GRANT_W-1:0] next_ptr(input logic [GRANT_W-1:0] p, input int nreq);
    return ptr_add(p, 1, nreq);
  endfunction

endpackage

// File: rtl/rr_bus_sched_if.sv
// rr_bus_sched_if: producer-side valid/ready lanes plus the shared registered output bus.
// Latency: n/a (wiring only).
// Backpressure: consumer stalls through out_ready; producers are throttled through req_ready.
interface rr_bus_sched_if
  import rr_bus_sched_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32
) ();

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  out_valid;
  logic [WIDTH-1:0]      out_data;
  logic                  out_ready;
  logic [GRANT_W-1:0]    grant_id;

  // Scheduler side.
  modport master (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, grant_id
  );

  // Producers and consumer side.
  modport slave (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, grant_id
  );

endinterface

// File: rtl/rr_bus_sched_pick.sv
// rr_pick: round-robin priority search, first valid requester at or after rr_ptr (mod NREQ).
// Latency: purely combinational.
// Backpressure: none; any_o low means nobody is asking.
module rr_pick
  import rr_bus_sched_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]    req_valid_i,
  input  logic [GRANT_W-1:0] rr_ptr_i,
  output logic [GRANT_W-1:0] sel_o,
  output logic               any_o
);

  logic [2*NREQ-1:0] rot;

  // Rotate so bit k is requester rr_ptr+k, then scan downward so the nearest one wins.
  always_comb begin
    rot   = {req_valid_i, req_valid_i} >> rr_ptr_i;
    sel_o = rr_ptr_i;
    any_o = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        sel_o = ptr_add(rr_ptr_i, k, NREQ);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_bus_sched.sv
// rr_bus_sched: shares one registered output bus among NREQ producers in round-robin bursts of up to BURST beats.
// Latency: a word accepted in cycle n is on out_data at edge n+1; 1 word/cycle while out_ready is high.
// Backpressure: output holds while out_valid && !out_ready; req_ready drops and the burst stalls in place.
// Optional per-requester saturating beat counters on grant_cnt when RR_BUS_SCHED_STATS_EN is defined.
module rr_bus_sched
  import rr_bus_sched_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32,
  parameter int BURST = 4,
  parameter logic [WIDTH-1:0] INIT_VAL = WIDTH'(INIT_VAL_DEF)
) (
  input  logic clk,
  input  logic rst,
`ifdef RR_BUS_SCHED_STATS_EN
  output logic [NREQ*STAT_W-1:0] grant_cnt,
`endif
  rr_bus_sched_if.master bus
);

  state_t             state_q;
  logic [GRANT_W-1:0] grant_id_q;
  logic [GRANT_W-1:0] rr_ptr_q;
  logic [BEAT_W-1:0]  beat_cnt_q;
  logic               out_valid_q;
  logic [WIDTH-1:0]   out_data_q = INIT_VAL;
  logic [WIDTH-1:0]   out_data_d;

  logic               acc;
  logic               owner_vld;
  logic               sel_vld;
  logic               xfer;
  logic [GRANT_W-1:0] sel;
  logic [GRANT_W-1:0] pick_sel;
  logic               pick_any;
  logic [NREQ-1:0]    ready_vec;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req_valid_i (bus.req_valid),
    .rr_ptr_i    (rr_ptr_q),
    .sel_o       (pick_sel),
    .any_o       (pick_any)
  );

  // Choose the source for this cycle and derive the one-hot accept and the data mux.
  always_comb begin
    acc       = !out_valid_q || bus.out_ready;
    owner_vld = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (GRANT_W'(i) == grant_id_q) owner_vld = bus.req_valid[i];
    end
    sel        = (state_q == IDLE) ? pick_sel : grant_id_q;
    sel_vld    = (state_q == IDLE) ? pick_any : owner_vld;
    xfer       = acc && sel_vld;
    ready_vec  = '0;
    out_data_d = out_data_q;
    for (int i = 0; i < NREQ; i++) begin
      if (GRANT_W'(i) == sel) begin
        ready_vec[i] = acc && ((state_q == OWN) || pick_any);
        if (xfer) out_data_d = bus.req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Grant FSM plus output register: ownership, burst counting, rotation and the held output word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_id_q  <= '0;
      rr_ptr_q    <= '0;
      beat_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= INIT_VAL;
    end else begin
      if (xfer) begin
        out_valid_q <= 1'b1;
        out_data_q  <= out_data_d;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (xfer) begin
            grant_id_q <= sel;
            if (BURST == 1) begin
              rr_ptr_q <= next_ptr(sel, NREQ);
            end else begin
              beat_cnt_q <= BEAT_W'(1);
              state_q    <= OWN;
            end
          end
        end
        OWN: begin
          // An owner that stops offering data gives up the bus at once, even under backpressure.
          if (!owner_vld) begin
            rr_ptr_q   <= next_ptr(grant_id_q, NREQ);
            beat_cnt_q <= '0;
            state_q    <= IDLE;
          end else if (xfer) begin
            if (beat_cnt_q == BEAT_W'(BURST - 1)) begin
              rr_ptr_q   <= next_ptr(grant_id_q, NREQ);
              beat_cnt_q <= '0;
              state_q    <= IDLE;
            end else begin
              beat_cnt_q <= beat_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = ready_vec;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.grant_id  = grant_id_q;

`ifdef RR_BUS_SCHED_STATS_EN
  logic [NREQ*STAT_W-1:0] grant_cnt_q;

  // Count accepted beats per requester, sticking at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req_valid[i] && ready_vec[i] &&
            (grant_cnt_q[i*STAT_W +: STAT_W] != {STAT_W{1'b1}})) begin
          grant_cnt_q[i*STAT_W +: STAT_W] <= grant_cnt_q[i*STAT_W +: STAT_W] + 1'b1;
        end
      end
    end
  end

  assign grant_cnt = grant_cnt_q;
`endif

endmodule

// File: tb/tb_rr_bus_sched.sv
// tb_rr_bus_sched: directed stimulus with a scoreboard of hand-computed {grant_id, out_data} words.
// Latency: n/a.
// Backpressure: the bench drives out_ready directly.
module tb_rr_bus_sched;
  import rr_bus_sched_pkg::*;

  localparam int NREQ  = 4;
  localparam int WIDTH = 32;
  localparam int BURST = 4;

  logic clk;
  logic rst;

  rr_bus_sched_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

`ifdef RR_BUS_SCHED_STATS_EN
  logic [NREQ*STAT_W-1:0] grant_cnt;
`endif

  rr_bus_sched #(
    .NREQ(NREQ), .WIDTH(WIDTH), .BURST(BURST), .INIT_VAL(32'd42)
  ) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef RR_BUS_SCHED_STATS_EN
    .grant_cnt (grant_cnt),
`endif
    .bus       (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [34:0] exp_q[$];
  logic [31:0] src_mem [NREQ][16];
  int          src_rd  [NREQ];
  int          src_wr  [NREQ];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Present the head of each source queue to the scheduler.
  task automatic refresh();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_valid[i] = (src_rd[i] < src_wr[i]);
      if (src_rd[i] < src_wr[i]) bus.req_data[i*WIDTH +: WIDTH] = src_mem[i][src_rd[i]];
      else bus.req_data[i*WIDTH +: WIDTH] = '0;
    end
  endtask

  task automatic load(input int i, input logic [31:0] d);
    src_mem[i][src_wr[i]] = d;
    src_wr[i]++;
    refresh();
  endtask

  task automatic expect_word(input int g, input logic [31:0] d);
    exp_q.push_back({3'(g), d});
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_sources();
    for (int i = 0; i < NREQ; i++) begin
      src_rd[i] = 0;
      src_wr[i] = 0;
    end
    refresh();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.out_ready = 1'b1;
    clear_sources();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (exp_q.size() != 0 && n < 300);
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  // Producer model: pop a source word after each handshake seen at the falling edge.
  initial begin
    logic [NREQ-1:0] hs;
    forever begin
      @(negedge clk);
      hs = rst ? '0 : (bus.req_valid & bus.req_ready);
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) if (hs[i]) src_rd[i]++;
      refresh();
    end
  end

  // Scoreboard monitor: every word the consumer takes must match the head of the expected queue.
  initial begin
    logic [34:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("ready_onehot", 64'($countones(bus.req_ready) <= 1), 64'd1);
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got grant %0d data %0h want none", bus.grant_id,
                     bus.out_data);
          end else begin
            e = exp_q.pop_front();
            chk("word", 64'({bus.grant_id, bus.out_data}), 64'(e));
          end
        end
      end
    end
  end

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.out_ready = 1'b1;
    rst = 1'b1;

    // Reset release with nothing requested.
    do_reset();
    tick();
    @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd42);
    chk("rst_grant_id", 64'(bus.grant_id), 64'd0);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);

    // Single requester 2.
    tick();
    load(2, 32'd66);
    expect_word(2, 32'd66);
    @(negedge clk);
    chk("single_req_ready", 64'(bus.req_ready), 64'b0100);
    tick();
    @(negedge clk);
    chk("single_out_valid", 64'(bus.out_valid), 64'd1);
    chk("single_out_data", 64'(bus.out_data), 64'd66);
    chk("single_grant_id", 64'(bus.grant_id), 64'd2);
    drain("single_drain");

    // All four streaming: bursts of four, rotating 0,1,2,3 then wrapping to 0.
    do_reset();
    for (int k = 0; k < 8; k++)
      for (int i = 0; i < NREQ; i++) load(i, (k << 8) | (i * 10 + 1));
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NREQ; i++)
        for (int b = 0; b < BURST; b++) expect_word(i, ((r * 4 + b) << 8) | (i * 10 + 1));
    drain("stream_drain");

    // Owner 1 runs dry after two beats; search resumes from 2, so 3 then 0.
    do_reset();
    load(0, 32'h500);
    expect_word(0, 32'h500);
    drain("drop_prep_drain");
    repeat (3) tick();
    load(1, 32'h511);
    load(1, 32'h512);
    for (int k = 0; k < 4; k++) begin
      load(0, 32'h601 + k);
      load(3, 32'h631 + k);
    end
    expect_word(1, 32'h511);
    expect_word(1, 32'h512);
    for (int k = 0; k < 4; k++) expect_word(3, 32'h631 + k);
    for (int k = 0; k < 4; k++) expect_word(0, 32'h601 + k);
    drain("drop_drain");

    // Consumer stalls for five cycles with 77 on the bus.
    do_reset();
    bus.out_ready = 1'b0;
    load(0, 32'd77);
    load(0, 32'd78);
    load(0, 32'd79);
    expect_word(0, 32'd77);
    expect_word(0, 32'd78);
    expect_word(0, 32'd79);
    tick();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
      chk("stall_out_data", 64'(bus.out_data), 64'd77);
      chk("stall_req_ready", 64'(bus.req_ready), 64'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    drain("stall_drain");

    // Reset asserted on beat 2 of a 4-beat burst.
    do_reset();
    for (int k = 0; k < 4; k++) load(0, 32'hA1 + k);
    expect_word(0, 32'hA1);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_out_data", 64'(bus.out_data), 64'd42);
    chk("midrst_grant_id", 64'(bus.grant_id), 64'd0);
    chk("midrst_pending", 64'(exp_q.size()), 64'd0);
    clear_sources();
`ifdef RR_BUS_SCHED_STATS_EN
    chk("stats_reset", 64'(grant_cnt), 64'd0);
`endif
    @(posedge clk);
    #2;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      load(0, 32'hB1 + k);
      expect_word(0, 32'hB1 + k);
    end
    drain("postrst_drain");
`ifdef RR_BUS_SCHED_STATS_EN
    chk("stats_three", 64'(grant_cnt), 64'd3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
